// File: rtl/ntt_unified_stream_if.sv
// Handshake bundle for ntt_unified_stream: job control, load/result streams
// and the combinational twiddle-ROM port.
interface ntt_unified_stream_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 8
);
    logic             start;
    logic             mode;
    logic             scale_en;
    logic             abort;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [AW-1:0]    tw_addr;
    logic             tw_inv;
    logic [WIDTH-1:0] tw_data;

    modport slave (
        input  start, mode, scale_en, abort, in_valid, in_data, out_ready, tw_data,
        output busy, done, in_ready, out_valid, out_data, out_last, tw_addr, tw_inv
    );

    modport master (
        output start, mode, scale_en, abort, in_valid, in_data, out_ready, tw_data,
        input  busy, done, in_ready, out_valid, out_data, out_last, tw_addr, tw_inv
    );
endinterface

// File: rtl/ntt_unified_stream.sv
// In-place streaming NTT/INTT engine: load N coefficients, run log2(N) butterfly
// stages through a fixed-latency modular multiplier, optionally scale, then unload.
module ntt_unified_stream #(
    parameter int N        = 256,
    parameter int WIDTH    = 32,
    parameter int Q        = 8380417,
    parameter int N_INV    = 8347681,
    parameter int MULT_LAT = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    ntt_unified_stream_if.slave bus
);
    localparam int LOGN = $clog2(N);
    localparam int AW   = LOGN;
    localparam int SW   = $clog2(LOGN);
    localparam int D    = MULT_LAT + 1;
    localparam int WW   = $clog2(D);

    localparam logic [WIDTH-1:0]   QW     = WIDTH'(Q);
    localparam logic [2*WIDTH-1:0] QW2    = (2*WIDTH)'(Q);
    localparam logic [WIDTH-1:0]   NINV_W = WIDTH'(N_INV);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] COMPUTE = 3'd2;
    localparam logic [2:0] SCALE   = 3'd3;
    localparam logic [2:0] UNLOAD  = 3'd4;

    localparam logic [1:0] OP_FWD = 2'd0;
    localparam logic [1:0] OP_INV = 2'd1;
    localparam logic [1:0] OP_SCL = 2'd2;

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] s;
        s = a + b;
        return (s >= QW) ? s - QW : s;
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a >= b) ? a - b : a + QW - b;
    endfunction

    logic [2:0]       state;
    logic             mode_r;
    logic             scale_r;
    logic [AW-1:0]    load_cnt;
    logic [AW-1:0]    out_cnt;
    logic [AW-1:0]    bf_cnt;
    logic [SW-1:0]    stage;
    logic             draining;
    logic [WW-1:0]    wait_cnt;
    logic             done_r;
    logic [WIDTH-1:0] mem [N];

    logic             aborting;
    logic             issue;
    logic [SW-1:0]    lg;
    logic [SW-1:0]    tw_shift;
    logic [AW-1:0]    group;
    logic [AW-1:0]    mask;
    logic [AW-1:0]    idx_a;
    logic [AW-1:0]    idx_b;
    logic [AW-1:0]    tw_calc;
    logic [AW-1:0]    rd_a_idx;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [1:0]       prep_op;
    logic [WIDTH-1:0] prep_x;
    logic [WIDTH-1:0] prep_y;
    logic [WIDTH-1:0] prep_add;

    logic [D-1:0]     pv;
    logic [1:0]       p_op  [D];
    logic [AW-1:0]    p_ia  [D];
    logic [AW-1:0]    p_ib  [D];
    logic [WIDTH-1:0] p_add [D];
    logic [WIDTH-1:0] p_val [D];
    logic [WIDTH-1:0] p_y;
    logic [2*WIDTH-1:0] prod_full;
    logic [WIDTH-1:0] prod_red;

    logic             wb_en;
    logic             wb_dual;
    logic [WIDTH-1:0] wa_data;
    logic [WIDTH-1:0] wb_data;

    assign aborting = bus.abort && (state != IDLE);
    assign issue    = ((state == COMPUTE) || (state == SCALE)) && !draining && !bus.abort;

    // Both directions share one index scheme: only the half-span exponent and
    // the twiddle base differ (forward len=N>>(s+1), inverse len=1<<s).
    always_comb begin
        lg       = mode_r ? stage : SW'(LOGN - 1) - stage;
        tw_shift = mode_r ? SW'(LOGN - 1) - stage : stage;
        group    = bf_cnt >> lg;
        mask     = (AW'(1) << lg) - AW'(1);
        idx_a    = (group << (lg + 1)) | (bf_cnt & mask);
        idx_b    = idx_a | (AW'(1) << lg);
        tw_calc  = (AW'(1) << tw_shift) + group;
        rd_a_idx = (state == SCALE) ? bf_cnt : idx_a;
        rd_a     = mem[rd_a_idx];
        rd_b     = mem[idx_b];
    end

    always_comb begin
        prep_op  = OP_FWD;
        prep_x   = rd_b;
        prep_y   = bus.tw_data;
        prep_add = rd_a;
        if (state == SCALE) begin
            prep_op  = OP_SCL;
            prep_x   = rd_a;
            prep_y   = NINV_W;
            prep_add = '0;
        end else if (mode_r) begin
            prep_op  = OP_INV;
            prep_x   = mod_sub(rd_a, rd_b);
            prep_add = mod_add(rd_a, rd_b);
        end
    end

    assign prod_full = {{WIDTH{1'b0}}, p_val[0]} * {{WIDTH{1'b0}}, p_y};
    assign prod_red  = WIDTH'(prod_full % QW2);

    // Data pipe: stage 0 holds multiplier operands, stage 1 the reduced product,
    // the remaining stages only delay it so write-back lands MULT_LAT+1 after issue.
    always_ff @(posedge clk) begin
        p_op[0]  <= prep_op;
        p_ia[0]  <= rd_a_idx;
        p_ib[0]  <= idx_b;
        p_add[0] <= prep_add;
        p_val[0] <= prep_x;
        p_y      <= prep_y;
        p_op[1]  <= p_op[0];
        p_ia[1]  <= p_ia[0];
        p_ib[1]  <= p_ib[0];
        p_add[1] <= p_add[0];
        p_val[1] <= prod_red;
        for (int k = 2; k < D; k++) begin
            p_op[k]  <= p_op[k-1];
            p_ia[k]  <= p_ia[k-1];
            p_ib[k]  <= p_ib[k-1];
            p_add[k] <= p_add[k-1];
            p_val[k] <= p_val[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else if (aborting) begin
            pv <= '0;
        end else begin
            pv <= {pv[D-2:0], issue};
        end
    end

    always_comb begin
        wb_en   = pv[D-1] && !bus.abort;
        wb_dual = 1'b1;
        wa_data = p_add[D-1];
        wb_data = p_val[D-1];
        case (p_op[D-1])
            OP_FWD: begin
                wa_data = mod_add(p_add[D-1], p_val[D-1]);
                wb_data = mod_sub(p_add[D-1], p_val[D-1]);
            end
            OP_SCL: begin
                wa_data = p_val[D-1];
                wb_dual = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if ((state == LOAD) && bus.in_valid && !bus.abort) begin
            mem[load_cnt] <= bus.in_data;
        end
        if (wb_en) begin
            mem[p_ia[D-1]] <= wa_data;
            if (wb_dual) begin
                mem[p_ib[D-1]] <= wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode_r   <= 1'b0;
            scale_r  <= 1'b0;
            load_cnt <= '0;
            out_cnt  <= '0;
            bf_cnt   <= '0;
            stage    <= '0;
            draining <= 1'b0;
            wait_cnt <= '0;
            done_r   <= 1'b0;
        end else if (aborting) begin
            state    <= IDLE;
            load_cnt <= '0;
            out_cnt  <= '0;
            bf_cnt   <= '0;
            stage    <= '0;
            draining <= 1'b0;
            wait_cnt <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        mode_r   <= bus.mode;
                        scale_r  <= bus.scale_en;
                        load_cnt <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        if (load_cnt == AW'(N - 1)) begin
                            state    <= COMPUTE;
                            bf_cnt   <= '0;
                            stage    <= '0;
                            draining <= 1'b0;
                        end else begin
                            load_cnt <= load_cnt + AW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (!draining) begin
                        if (bf_cnt == AW'(N/2 - 1)) begin
                            bf_cnt   <= '0;
                            draining <= 1'b1;
                            wait_cnt <= '0;
                        end else begin
                            bf_cnt <= bf_cnt + AW'(1);
                        end
                    end else if (wait_cnt == WW'(D - 1)) begin
                        draining <= 1'b0;
                        if (stage == SW'(LOGN - 1)) begin
                            stage   <= '0;
                            out_cnt <= '0;
                            state   <= (mode_r && scale_r) ? SCALE : UNLOAD;
                        end else begin
                            stage <= stage + SW'(1);
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                SCALE: begin
                    if (!draining) begin
                        if (bf_cnt == AW'(N - 1)) begin
                            bf_cnt   <= '0;
                            draining <= 1'b1;
                            wait_cnt <= '0;
                        end else begin
                            bf_cnt <= bf_cnt + AW'(1);
                        end
                    end else if (wait_cnt == WW'(D - 1)) begin
                        draining <= 1'b0;
                        out_cnt  <= '0;
                        state    <= UNLOAD;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                UNLOAD: begin
                    if (bus.out_ready) begin
                        if (out_cnt == AW'(N - 1)) begin
                            out_cnt <= '0;
                            done_r  <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            out_cnt <= out_cnt + AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;
    assign bus.in_ready  = (state == LOAD);
    assign bus.out_valid = (state == UNLOAD);
    assign bus.out_data  = (state == UNLOAD) ? mem[out_cnt] : '0;
    assign bus.out_last  = (state == UNLOAD) && (out_cnt == AW'(N - 1));
    assign bus.tw_addr   = ((state == COMPUTE) && !draining) ? tw_calc : '0;
    assign bus.tw_inv    = mode_r;
endmodule
